mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Bridges an RV32I load/store request from the CPU onto a single-outstanding
// memory bus transaction and returns the sign/zero-extended load result.
//
// Ports:
//   i_clk, i_rst          clock and asynchronous active-high reset
//   i_req, i_we           request strobe (sampled when o_ready=1), 1=store
//   i_funct3              RV32I width code
//   i_addr, i_wdata       byte address and right-justified store data
//   o_ready               1 while idle and able to accept a request
//   o_done, o_err         completion pulse and its error qualifier
//   o_rdata               extended load result, held until the next o_done
//   o_bus_*               transaction start pulse plus address/size/data/direction
//   i_bus_data, i_bus_DV  read data and transaction-complete pulse from the bus
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [31:0] o_bus_data,
  output logic [31:0] o_bus_address,
  output logic        o_bus_DV,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_count;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [2:0]  r_bhw;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        w_legal;
  logic        w_accept;
  logic        w_timeout;
  logic        w_complete;
  logic [31:0] w_ext;
  logic [2:0]  w_bhw;

  // A request is legal only for the width codes RV32I defines for its
  // direction; anything else is answered locally without touching the bus.
  always_comb begin
    w_legal = 1'b0;
    if (i_we) begin
      w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
    end else begin
      w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
    end
  end

  // Byte-count encoding derived from the low two funct3 bits at acceptance,
  // registered so it reads as zero while in reset.
  always_comb begin
    w_bhw = 3'b001;
    case (i_funct3[1:0])
      2'b10:   w_bhw = 3'b100;
      2'b01:   w_bhw = 3'b010;
      default: w_bhw = 3'b001;
    endcase
  end

  // Load extension: upper bus bytes beyond the access width are don't-care,
  // so they are masked before sign or zero extension.
  always_comb begin
    w_ext = 32'h0;
    case (r_funct3)
      3'b000:  w_ext = {{24{i_bus_data[7]}}, i_bus_data[7:0]};
      3'b001:  w_ext = {{16{i_bus_data[15]}}, i_bus_data[15:0]};
      3'b010:  w_ext = i_bus_data;
      3'b100:  w_ext = {24'h0, i_bus_data[7:0]};
      3'b101:  w_ext = {16'h0, i_bus_data[15:0]};
      default: w_ext = 32'h0;
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && i_req;
  assign w_complete = (r_state == S_WAIT) && i_bus_DV;
  assign w_timeout  = (r_state == S_WAIT) && !i_bus_DV && (r_count == TO_LAST);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Illegal requests reuse DONE for their one-cycle error
  // pulse. A timeout moves to DRAIN so the late response of the abandoned
  // transaction is swallowed before another one may start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_next = w_legal ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (i_bus_DV) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next = S_DRAIN;
        end
      end
      S_DONE: w_next = S_IDLE;
      S_DRAIN: begin
        if (i_bus_DV) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Timeout counter: zeroed while issuing so it starts at 0 on the first
  // WAIT cycle, then counts WAIT cycles that pass without a response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 16'h0;
    end else if (r_state == S_ISSUE) begin
      r_count <= 16'h0;
    end else if ((r_state == S_WAIT) && !i_bus_DV) begin
      r_count <= r_count + 16'h1;
    end
  end

  // Request latch and completion registers. o_done/o_err are single-cycle
  // pulses; o_rdata only changes when a completion is reported, and is zero
  // for stores, illegal requests and timeouts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_bhw    <= 3'b000;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept && w_legal) begin
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
        r_we     <= i_we;
        r_funct3 <= i_funct3;
        r_bhw    <= w_bhw;
      end
      if (w_accept && !w_legal) begin
        r_done  <= 1'b1;
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end
      if (w_complete) begin
        r_done  <= 1'b1;
        r_err   <= 1'b0;
        r_rdata <= r_we ? 32'h0 : w_ext;
      end
      if (w_timeout) begin
        r_done  <= 1'b1;
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end
    end
  end

  assign o_ready         = (r_state == S_IDLE);
  assign o_bus_DV        = (r_state == S_ISSUE);
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_rdata         = r_rdata;
  assign o_bus_address   = r_addr;
  assign o_bus_data      = r_wdata;
  assign o_write_notread = r_we;
  assign o_bhw           = r_bhw;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit with TIMEOUT_CYCLES=8. Inputs change
// 1 ns after each rising edge and outputs are checked at that same point.
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_ready;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [31:0] o_bus_data;
  logic [31:0] o_bus_address;
  logic        o_bus_DV;
  logic [2:0]  o_bhw;
  logic        o_write_notread;
  logic [31:0] i_bus_data = 32'h0;
  logic        i_bus_DV = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req           (i_req),
    .i_we            (i_we),
    .i_funct3        (i_funct3),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .o_ready         (o_ready),
    .o_done          (o_done),
    .o_rdata         (o_rdata),
    .o_err           (o_err),
    .o_bus_data      (o_bus_data),
    .o_bus_address   (o_bus_address),
    .o_bus_DV        (o_bus_DV),
    .o_bhw           (o_bhw),
    .o_write_notread (o_write_notread),
    .i_bus_data      (i_bus_data),
    .i_bus_DV        (i_bus_DV)
  );

  // Free-running 100 MHz clock.
  always #5 i_clk = ~i_clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one CPU request for the coming edge.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    i_req    = 1'b1;
    i_we     = we;
    i_funct3 = f3;
    i_addr   = addr;
    i_wdata  = wdata;
  endtask

  // Full legal transaction: request, ISSUE checks, `idle` silent WAIT cycles,
  // then a bus response and the completion checks.
  task automatic runTransaction(input string tag, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] busData, input int idle,
                                input logic [31:0] expRdata, input logic [2:0] expBhw);
    checkOutput({tag, ".ready"}, o_ready, 1);
    applyStimulus(we, f3, addr, wdata);
    tick();
    i_req = 1'b0;
    checkOutput({tag, ".busDV"}, o_bus_DV, 1);
    checkOutput({tag, ".addr"}, o_bus_address, addr);
    checkOutput({tag, ".bhw"}, o_bhw, expBhw);
    checkOutput({tag, ".wnr"}, o_write_notread, we);
    checkOutput({tag, ".bdata"}, o_bus_data, wdata);
    tick();
    for (int k = 0; k < idle; k++) begin
      checkOutput({tag, ".waitDV"}, o_bus_DV, 0);
      checkOutput({tag, ".waitDone"}, o_done, 0);
      checkOutput({tag, ".holdAddr"}, o_bus_address, addr);
      tick();
    end
    i_bus_DV   = 1'b1;
    i_bus_data = busData;
    tick();
    i_bus_DV = 1'b0;
    checkOutput({tag, ".done"}, o_done, 1);
    checkOutput({tag, ".err"}, o_err, 0);
    checkOutput({tag, ".rdata"}, o_rdata, expRdata);
    tick();
    checkOutput({tag, ".donePulse"}, o_done, 0);
    checkOutput({tag, ".rdataHeld"}, o_rdata, expRdata);
    checkOutput({tag, ".readyAfter"}, o_ready, 1);
  endtask

  // Directed scenario sequence.
  initial begin
    $display("[TB] start");
    i_rst = 1'b1;
    #1;
    checkOutput("rst.ready", o_ready, 1);
    checkOutput("rst.done", o_done, 0);
    checkOutput("rst.busDV", o_bus_DV, 0);
    checkOutput("rst.bhw", o_bhw, 0);
    checkOutput("rst.rdata", o_rdata, 0);
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    runTransaction("LB", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'hDEAD_BE80, 0, 32'hFFFF_FF80, 3'b001);
    runTransaction("LHU", 1'b0, 3'b101, 32'h0000_2001, 32'h0, 32'h1234_F00D, 1, 32'h0000_F00D, 3'b010);
    runTransaction("LH", 1'b0, 3'b001, 32'h0000_2001, 32'h0, 32'h1234_F00D, 2, 32'hFFFF_F00D, 3'b010);
    runTransaction("LBU", 1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'hABCD_EF9A, 0, 32'h0000_009A, 3'b001);
    runTransaction("LW", 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h89AB_CDEF, 3, 32'h89AB_CDEF, 3'b100);
    runTransaction("SW", 1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_BABE, 32'hFFFF_FFFF, 4, 32'h0, 3'b100);
    runTransaction("SB", 1'b1, 3'b000, 32'h0000_3001, 32'h1122_3344, 32'h0, 0, 32'h0, 3'b001);

    // Illegal load width: local error, then a back-to-back legal request.
    runTransaction("LWpre", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h5555_AAAA, 0, 32'h5555_AAAA, 3'b100);
    applyStimulus(1'b0, 3'b011, 32'h0000_6000, 32'h0);
    tick();
    i_req = 1'b0;
    checkOutput("ill.busDV", o_bus_DV, 0);
    checkOutput("ill.done", o_done, 1);
    checkOutput("ill.err", o_err, 1);
    checkOutput("ill.rdata", o_rdata, 0);
    tick();
    runTransaction("LWb2b", 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 3'b100);

    // Illegal store width.
    applyStimulus(1'b1, 3'b100, 32'h0000_6008, 32'h1234_5678);
    tick();
    i_req = 1'b0;
    checkOutput("illSt.busDV", o_bus_DV, 0);
    checkOutput("illSt.err", o_err, 1);
    tick();

    // Timeout after 8 silent WAIT cycles, then drain the late response.
    applyStimulus(1'b0, 3'b010, 32'h0000_7000, 32'h0);
    tick();
    i_req = 1'b0;
    checkOutput("to.busDV", o_bus_DV, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      checkOutput("to.waitDone", o_done, 0);
      checkOutput("to.waitReady", o_ready, 0);
      tick();
    end
    checkOutput("to.done", o_done, 1);
    checkOutput("to.err", o_err, 1);
    checkOutput("to.rdata", o_rdata, 0);
    checkOutput("to.readyDrain", o_ready, 0);
    tick();
    checkOutput("to.donePulse", o_done, 0);
    checkOutput("to.drainReady", o_ready, 0);
    checkOutput("to.drainBusDV", o_bus_DV, 0);
    i_bus_DV   = 1'b1;
    i_bus_data = 32'h1111_1111;
    tick();
    i_bus_DV = 1'b0;
    checkOutput("to.lateReady", o_ready, 1);
    checkOutput("to.lateDone", o_done, 0);
    checkOutput("to.lateRdata", o_rdata, 0);

    // Response on the 8th WAIT cycle still completes normally.
    runTransaction("edge8", 1'b0, 3'b010, 32'h0000_7004, 32'h0, 32'h7777_0001, 7, 32'h7777_0001, 3'b100);

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(1'b1, 3'b001, 32'h0000_8000, 32'hFFFF_1234);
    tick();
    i_req = 1'b0;
    tick();
    i_rst = 1'b1;
    #1;
    checkOutput("arst.ready", o_ready, 1);
    checkOutput("arst.wnr", o_write_notread, 0);
    checkOutput("arst.addr", o_bus_address, 0);
    checkOutput("arst.bdata", o_bus_data, 0);
    checkOutput("arst.bhw", o_bhw, 0);
    checkOutput("arst.rdata", o_rdata, 0);
    checkOutput("arst.err", o_err, 0);
    tick();
    i_rst = 1'b0;
    tick();
    i_bus_DV = 1'b1;
    tick();
    i_bus_DV = 1'b0;
    checkOutput("arst.staleDone", o_done, 0);
    checkOutput("arst.staleReady", o_ready, 1);
    runTransaction("post", 1'b0, 3'b000, 32'h0000_9000, 32'h0, 32'h0000_007F, 1, 32'h0000_007F, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
